// File: rtl/binary_mul_pkg.sv
// Shared types and constants for the multiplier accumulate stage.
// The saturation limits are computed from the accumulator width.
package binary_mul_pkg;

  localparam int P_W_DEF   = 23;
  localparam int ACC_W_DEF = 32;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/binary_mul_acc_12_if.sv
// Product-in / result-out handshake bundle for binary_mul_acc_12.
// The master drives products and accepts results; the slave is the accumulator.
interface binary_mul_acc_12_if
  import binary_mul_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  logic signed [P_W-1:0]   p;
  logic                    p_valid;
  logic                    p_ready;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_valid;
  logic                    acc_ready;
  logic                    ovf;
  logic [CNT_W-1:0]        cnt;

  modport master (
    output p, p_valid, acc_ready,
    input  p_ready, acc, acc_valid, ovf, cnt
  );

  modport slave (
    input  p, p_valid, acc_ready,
    output p_ready, acc, acc_valid, ovf, cnt
  );
endinterface

// File: rtl/sat_add_s.sv
// Signed accumulator adder: acc + sext(product), with optional clamp.
// o_ovf flags a result that does not fit in ACC_W bits, whether clamped or wrapped.
module sat_add_s
  import binary_mul_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [P_W-1:0]   i_b,
  input  logic                    i_sat,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic signed [ACC_W:0] w_wide;

  always_comb begin
    w_wide = (ACC_W + 1)'(i_a) + (ACC_W + 1)'(i_b);
    // The extra top bit disagreeing with the sign bit means the true sum left the ACC_W range.
    o_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    if (o_ovf && i_sat) begin
      o_sum = w_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      o_sum = w_wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/binary_mul_acc_12.sv
// Accumulates LEN signed products into one dot-product result with a valid/ready
// handshake on both sides; the product source is stalled while a result waits.
module binary_mul_acc_12
  import binary_mul_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = 16,
  parameter bit SAT   = 1'b1
) (
  input logic                i_clk,
  input logic                i_rst,
  input logic                i_en,
  input logic                i_clr,
  binary_mul_acc_12_if.slave bus
);

  state_e                  r_state;
  state_e                  w_next_state;
  logic signed [ACC_W-1:0] r_sum;
  logic signed [ACC_W-1:0] w_add_sum;
  logic                    r_ovf;
  logic                    w_add_ovf;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_p_ready;
  logic                    w_acc_valid;
  logic                    w_accept;
  logic                    w_deliver;
  logic                    w_last;

  sat_add_s #(
    .P_W   (P_W),
    .ACC_W (ACC_W)
  ) u_add (
    .i_a   (r_sum),
    .i_b   (bus.p),
    .i_sat (SAT),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  assign w_accept  = i_en & bus.p_valid & w_p_ready;
  assign w_deliver = i_en & w_acc_valid & bus.acc_ready;
  // Counter still holds the pre-accept value, so LEN==1 lands here straight from IDLE.
  assign w_last    = (r_cnt == CNT_W'(LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else if (i_en) begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    if (i_clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_next_state = w_last ? ST_DONE : ST_ACCUM;
        ST_ACCUM: if (w_accept && w_last) w_next_state = ST_DONE;
        ST_DONE:  if (w_deliver) w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_p_ready   = i_en & ~i_clr & ~i_rst & (r_state != ST_DONE);
    w_acc_valid = (r_state == ST_DONE);
  end

  // Accept and deliver are exclusive because p_ready is low in DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr || w_deliver) begin
        r_sum <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sum <= w_add_sum;
        r_ovf <= r_ovf | w_add_ovf;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.p_ready   = w_p_ready;
  assign bus.acc_valid = w_acc_valid;
  assign bus.acc       = r_sum;
  assign bus.ovf       = r_ovf;
  assign bus.cnt       = r_cnt;

endmodule

// File: tb/tb_binary_mul_acc_12.sv
// Self-checking bench: five accumulator configurations share one stimulus stream;
// a selector picks which instance the current scenario observes.
module tb_binary_mul_acc_12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b1;
  logic              clr = 1'b0;
  logic signed [22:0] p  = '0;
  logic              p_valid   = 1'b0;
  logic              acc_ready = 1'b0;

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  int len_t  [5] = '{4, 16, 3, 3, 1};
  int accw_t [5] = '{32, 32, 24, 24, 23};
  bit sat_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  binary_mul_acc_12_if #(.P_W(23), .ACC_W(32)) if_a ();
  binary_mul_acc_12_if #(.P_W(23), .ACC_W(32)) if_b ();
  binary_mul_acc_12_if #(.P_W(23), .ACC_W(24)) if_c ();
  binary_mul_acc_12_if #(.P_W(23), .ACC_W(24)) if_d ();
  binary_mul_acc_12_if #(.P_W(23), .ACC_W(23)) if_e ();

  assign if_a.p = p;  assign if_a.p_valid = p_valid;  assign if_a.acc_ready = acc_ready;
  assign if_b.p = p;  assign if_b.p_valid = p_valid;  assign if_b.acc_ready = acc_ready;
  assign if_c.p = p;  assign if_c.p_valid = p_valid;  assign if_c.acc_ready = acc_ready;
  assign if_d.p = p;  assign if_d.p_valid = p_valid;  assign if_d.acc_ready = acc_ready;
  assign if_e.p = p;  assign if_e.p_valid = p_valid;  assign if_e.acc_ready = acc_ready;

  binary_mul_acc_12 #(.P_W(23), .ACC_W(32), .LEN(4), .SAT(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .bus(if_a));
  binary_mul_acc_12 #(.P_W(23), .ACC_W(32), .LEN(16), .SAT(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .bus(if_b));
  binary_mul_acc_12 #(.P_W(23), .ACC_W(24), .LEN(3), .SAT(1'b1)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .bus(if_c));
  binary_mul_acc_12 #(.P_W(23), .ACC_W(24), .LEN(3), .SAT(1'b0)) u_dut_d (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .bus(if_d));
  binary_mul_acc_12 #(.P_W(23), .ACC_W(23), .LEN(1), .SAT(1'b0)) u_dut_e (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .bus(if_e));

  logic        sel_p_ready, sel_acc_valid, sel_ovf;
  logic [15:0] sel_cnt;
  longint      sel_acc;

  always_comb begin
    sel_p_ready = if_a.p_ready; sel_acc_valid = if_a.acc_valid;
    sel_ovf = if_a.ovf; sel_cnt = if_a.cnt; sel_acc = longint'(if_a.acc);
    case (sel)
      1: begin sel_p_ready = if_b.p_ready; sel_acc_valid = if_b.acc_valid;
               sel_ovf = if_b.ovf; sel_cnt = if_b.cnt; sel_acc = longint'(if_b.acc); end
      2: begin sel_p_ready = if_c.p_ready; sel_acc_valid = if_c.acc_valid;
               sel_ovf = if_c.ovf; sel_cnt = if_c.cnt; sel_acc = longint'(if_c.acc); end
      3: begin sel_p_ready = if_d.p_ready; sel_acc_valid = if_d.acc_valid;
               sel_ovf = if_d.ovf; sel_cnt = if_d.cnt; sel_acc = longint'(if_d.acc); end
      4: begin sel_p_ready = if_e.p_ready; sel_acc_valid = if_e.acc_valid;
               sel_ovf = if_e.ovf; sel_cnt = if_e.cnt; sel_acc = longint'(if_e.acc); end
      default: ;
    endcase
  end

  // Reference: exact integer running sum, clamped or wrapped whenever it leaves the signed range.
  function automatic longint ref_sum(input longint vals[$], input int accw, input bit sat,
                                     output bit ovf);
    longint s, t, rng, mx, mn;
    rng = longint'(1) <<< accw;
    mx  = rng / 2 - 1;
    mn  = -(rng / 2);
    s   = 0;
    ovf = 1'b0;
    foreach (vals[i]) begin
      t = s + vals[i];
      if (t > mx || t < mn) begin
        ovf = 1'b1;
        if (sat) t = (t > mx) ? mx : mn;
        else     t = (t > mx) ? t - rng : t + rng;
      end
      s = t;
    end
    return s;
  endfunction

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Presents one product and waits (bounded) until the selected instance accepts it.
  task automatic send(input logic signed [22:0] v);
    int n = 0;
    p = v;
    p_valid = 1'b1;
    #1;
    while (!sel_p_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sel_p_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout p_ready=%0b required=1", sel_p_ready);
    end
    @(posedge clk);
    @(negedge clk);
    p_valid = 1'b0;
    p = 23'($urandom);
  endtask

  task automatic get_result(output longint a, output bit o);
    int n = 0;
    while (!sel_acc_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sel_acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout acc_valid=%0b required=1", sel_acc_valid);
    end
    a = sel_acc;
    o = sel_ovf;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    p_valid = 1'b1;
    rst = 1'b1;
    for (int s = 0; s < 5; s++) begin
      sel = s;
      #1;
      checks++;
      if ({sel_p_ready, sel_acc_valid, sel_ovf} !== 3'b000 || sel_cnt !== 16'd0 || sel_acc !== 0) begin
        failures++;
        $display("FAIL reset_state inst=%0d p_ready=%0b acc_valid=%0b ovf=%0b cnt=%0d acc=%0d required all 0",
                 s, sel_p_ready, sel_acc_valid, sel_ovf, sel_cnt, sel_acc);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    p_valid = 1'b0;
    sel = 0;
    #1;
    checks++;
    if (sel_p_ready !== 1'b1 || sel_acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release p_ready=%0b acc_valid=%0b required 1/0", sel_p_ready, sel_acc_valid);
    end
  endtask

  task automatic test_basic();
    sel = 0;
    clr_pulse();
    send(23'sd1); send(23'sd2); send(23'sd3);
    checks++;
    if (sel_acc_valid !== 1'b0 || sel_cnt !== 16'd3 || sel_acc !== 6) begin
      failures++;
      $display("FAIL basic_partial acc_valid=%0b cnt=%0d acc=%0d required 0/3/6", sel_acc_valid, sel_cnt, sel_acc);
    end
    send(23'sd4);
    #1;
    checks++;
    if (sel_acc_valid !== 1'b1 || sel_acc !== 10 || sel_ovf !== 1'b0 || sel_p_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_result acc_valid=%0b acc=%0d ovf=%0b p_ready=%0b required 1/10/0/0",
               sel_acc_valid, sel_acc, sel_ovf, sel_p_ready);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    #1;
    checks++;
    if (sel_acc_valid !== 1'b0 || sel_cnt !== 16'd0 || sel_p_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle acc_valid=%0b cnt=%0d p_ready=%0b required 0/0/1", sel_acc_valid, sel_cnt, sel_p_ready);
    end
  endtask

  // +2^22 does not fit a 23-bit signed product; the extremes are +2^22-1 and -2^22.
  task automatic test_worst_case();
    longint a;
    bit     o;
    sel = 1;
    clr_pulse();
    repeat (16) send(23'sd4194303);
    get_result(a, o);
    checks++;
    if (a !== 67108848 || o !== 1'b0) begin
      failures++;
      $display("FAIL worst_pos acc=%0d ovf=%0b required 67108848/0", a, o);
    end
    repeat (16) send(-23'sd4194304);
    get_result(a, o);
    checks++;
    if (a !== -67108864 || o !== 1'b0) begin
      failures++;
      $display("FAIL worst_neg acc=%0d ovf=%0b required -67108864/0", a, o);
    end
  endtask

  task automatic test_saturation();
    sel = 2;
    clr_pulse();
    repeat (3) send(23'sd4194303);
    #1;
    checks++;
    if (longint'(if_c.acc) !== 8388607 || if_c.ovf !== 1'b1 || if_c.acc_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos acc=%0d ovf=%0b required 8388607/1", if_c.acc, if_c.ovf);
    end
    checks++;
    if (longint'(if_d.acc) !== -4194307 || if_d.ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pos acc=%0d ovf=%0b required -4194307/1", if_d.acc, if_d.ovf);
    end
    clr_pulse();
    #1;
    checks++;
    if (if_c.acc_valid !== 1'b0 || if_c.ovf !== 1'b0 || if_c.acc !== 24'sd0) begin
      failures++;
      $display("FAIL clr_in_done acc_valid=%0b ovf=%0b acc=%0d required 0/0/0", if_c.acc_valid, if_c.ovf, if_c.acc);
    end
    repeat (3) send(-23'sd4194304);
    #1;
    checks++;
    if (longint'(if_c.acc) !== -8388608 || if_c.ovf !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg acc=%0d ovf=%0b required -8388608/1", if_c.acc, if_c.ovf);
    end
    checks++;
    if (longint'(if_d.acc) !== 4194304 || if_d.ovf !== 1'b1) begin
      failures++;
      $display("FAIL wrap_neg acc=%0d ovf=%0b required 4194304/1", if_d.acc, if_d.ovf);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    #1;
    checks++;
    if (if_c.ovf !== 1'b0 || if_d.ovf !== 1'b0 || if_c.acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear_on_deliver ovf_c=%0b ovf_d=%0b valid=%0b required 0/0/0", if_c.ovf, if_d.ovf, if_c.acc_valid);
    end
  endtask

  task automatic test_backpressure();
    sel = 2;
    clr_pulse();
    send(-23'sd5); send(23'sd7); send(23'sd0);
    p = 23'sd9;
    p_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (sel_acc !== 2 || sel_acc_valid !== 1'b1 || sel_p_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d acc=%0d acc_valid=%0b p_ready=%0b required 2/1/0",
                 i, sel_acc, sel_acc_valid, sel_p_ready);
      end
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    #1;
    checks++;
    if (sel_acc_valid !== 1'b0 || sel_p_ready !== 1'b1 || sel_cnt !== 16'd0) begin
      failures++;
      $display("FAIL backpressure_release acc_valid=%0b p_ready=%0b cnt=%0d required 0/1/0",
               sel_acc_valid, sel_p_ready, sel_cnt);
    end
    @(negedge clk);
    p_valid = 1'b0;
    checks++;
    if (sel_cnt !== 16'd1 || sel_acc !== 9) begin
      failures++;
      $display("FAIL backpressure_next_first cnt=%0d acc=%0d required 1/9", sel_cnt, sel_acc);
    end
  endtask

  task automatic test_clear();
    longint a;
    bit     o;
    sel = 0;
    clr_pulse();
    repeat (3) send(23'sd100);
    p = 23'sd100;
    p_valid = 1'b1;
    clr = 1'b1;
    #1;
    checks++;
    if (sel_p_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_blocks_accept p_ready=%0b required 0", sel_p_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    p_valid = 1'b0;
    checks++;
    if (sel_cnt !== 16'd0 || sel_acc !== 0 || sel_acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_state cnt=%0d acc=%0d acc_valid=%0b required 0/0/0", sel_cnt, sel_acc, sel_acc_valid);
    end
    send(23'sd1);
    checks++;
    if (sel_cnt !== 16'd1) begin
      failures++;
      $display("FAIL clr_restart cnt=%0d required 1", sel_cnt);
    end
    repeat (3) send(23'sd1);
    get_result(a, o);
    checks++;
    if (a !== 4 || o !== 1'b0) begin
      failures++;
      $display("FAIL clr_result acc=%0d ovf=%0b required 4/0", a, o);
    end
  endtask

  task automatic test_async_reset();
    sel = 0;
    clr_pulse();
    send(23'sd5); send(23'sd6);
    checks++;
    if (sel_cnt !== 16'd2) begin
      failures++;
      $display("FAIL rst_pre cnt=%0d required 2", sel_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sel_cnt !== 16'd0 || sel_acc !== 0 || sel_p_ready !== 1'b0 || sel_acc_valid !== 1'b0 || sel_ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_async cnt=%0d acc=%0d p_ready=%0b acc_valid=%0b ovf=%0b required all 0",
               sel_cnt, sel_acc, sel_p_ready, sel_acc_valid, sel_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enable_freeze();
    logic signed [22:0] v [4];
    longint vals[$];
    longint a, exp_a;
    bit     o, exp_o;
    sel = 0;
    clr_pulse();
    for (int i = 0; i < 4; i++) begin
      v[i] = 23'($urandom_range(0, 20000)) - 23'sd10000;
      vals.push_back(longint'(v[i]));
    end
    send(v[0]); send(v[1]);
    en = 1'b0;
    p = 23'sd1234;
    p_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (sel_cnt !== 16'd2 || sel_acc !== vals[0] + vals[1] || sel_p_ready !== 1'b0) begin
        failures++;
        $display("FAIL en_freeze cyc=%0d cnt=%0d acc=%0d p_ready=%0b required 2/%0d/0",
                 i, sel_cnt, sel_acc, sel_p_ready, vals[0] + vals[1]);
      end
    end
    en = 1'b1;
    p_valid = 1'b0;
    send(v[2]); send(v[3]);
    exp_a = ref_sum(vals, accw_t[0], sat_t[0], exp_o);
    en = 1'b0;
    acc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sel_acc_valid !== 1'b1 || sel_acc !== exp_a) begin
        failures++;
        $display("FAIL en_hold_done cyc=%0d acc_valid=%0b acc=%0d required 1/%0d", i, sel_acc_valid, sel_acc, exp_a);
      end
    end
    en = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    checks++;
    if (sel_acc_valid !== 1'b0) begin
      failures++;
      $display("FAIL en_resume_deliver acc_valid=%0b required 0", sel_acc_valid);
    end
    a = exp_a;
    o = exp_o;
  endtask

  task automatic test_random();
    longint vals[$];
    longint a, exp_a;
    bit     o, exp_o;
    logic signed [22:0] v;
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 4);
      clr_pulse();
      vals.delete();
      for (int i = 0; i < len_t[sel]; i++) begin
        repeat ($urandom_range(0, 2)) begin
          p_valid = 1'b0;
          p = 23'($urandom);
          @(negedge clk);
        end
        case ($urandom_range(0, 3))
          0: v = 23'($urandom_range(0, 200)) - 23'sd100;
          1: v = $urandom_range(0, 1) ? 23'sd4194303 : -23'sd4194304;
          default: v = 23'($urandom);
        endcase
        vals.push_back(longint'(v));
        send(v);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      get_result(a, o);
      exp_a = ref_sum(vals, accw_t[sel], sat_t[sel], exp_o);
      checks++;
      if (a !== exp_a || o !== exp_o) begin
        failures++;
        $display("FAIL random vec=%0d inst=%0d acc=%0d ovf=%0b required %0d/%0b", k, sel, a, o, exp_a, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_worst_case();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_enable_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
